// File: rtl/keyboard_pkg.sv
// Shared scan-code constants, decoder state type and frame-check helper for the PS/2 keyboard front end.
package keyboard_pkg;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_D     = 8'h23;

   localparam int unsigned FRAME_BITS = 11;
   localparam int unsigned BIT_CNT_W  = 4;

   typedef enum logic [1:0] {
      DEC_IDLE,
      DEC_EXT,
      DEC_BREAK,
      DEC_EXT_BREAK
   } dec_state_t;

   // Odd parity across data+parity and a high stop bit mark a good frame.
   function automatic logic frame_ok(input logic [7:0] data, input logic par, input logic stop);
      return (^{data, par}) & stop;
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pin synchroniser, falling-edge sampler, frame check and
// inactivity timeout that aborts a partial frame.
module ps2_rx
   import keyboard_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 65_000,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] scan_code,
   output logic       scan_valid,
   output logic       frame_err
);

   localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned LAST_BIT = FRAME_BITS - 1;

   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
   logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
   logic                   clk_prev_q, clk_prev_d;
   logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [7:0]             shift_q, shift_d;
   logic                   par_q, par_d;
   logic [TMO_W-1:0]       tmo_q, tmo_d;
   logic [7:0]             scan_code_q, scan_code_d;
   logic                   scan_valid_q, scan_valid_d;
   logic                   frame_err_q, frame_err_d;

   logic clk_s_c;
   logic data_s_c;
   logic fall_c;

   assign clk_s_c  = clk_sync_q[SYNC_STAGES-1];
   assign data_s_c = data_sync_q[SYNC_STAGES-1];
   assign fall_c   = clk_prev_q & ~clk_s_c;

   always_comb begin
      clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_d   = clk_s_c;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      par_d        = par_q;
      tmo_d        = tmo_q;
      scan_code_d  = scan_code_q;
      scan_valid_d = 1'b0;
      frame_err_d  = 1'b0;

      if (fall_c) begin
         tmo_d = '0;
         if (bit_cnt_q == '0) begin
            // A high start bit is line noise, not a frame.
            if (!data_s_c) bit_cnt_d = BIT_CNT_W'(1);
         end else if (bit_cnt_q <= BIT_CNT_W'(8)) begin
            shift_d   = {data_s_c, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
         end else if (bit_cnt_q < BIT_CNT_W'(LAST_BIT)) begin
            par_d     = data_s_c;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
         end else begin
            bit_cnt_d = '0;
            if (frame_ok(shift_q, par_q, data_s_c)) begin
               scan_code_d  = shift_q;
               scan_valid_d = 1'b1;
            end else begin
               frame_err_d = 1'b1;
            end
         end
      end else if (bit_cnt_q != '0) begin
         if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            bit_cnt_d   = '0;
            tmo_d       = '0;
            frame_err_d = 1'b1;
         end else begin
            tmo_d = tmo_q + TMO_W'(1);
         end
      end else begin
         tmo_d = '0;
      end
   end

   // Synchroniser resets to the idle-high line level so reset release cannot fake an edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_sync_q   <= '1;
         data_sync_q  <= '1;
         clk_prev_q   <= 1'b1;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         par_q        <= 1'b0;
         tmo_q        <= '0;
         scan_code_q  <= '0;
         scan_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         clk_sync_q   <= clk_sync_d;
         data_sync_q  <= data_sync_d;
         clk_prev_q   <= clk_prev_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         par_q        <= par_d;
         tmo_q        <= tmo_d;
         scan_code_q  <= scan_code_d;
         scan_valid_q <= scan_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign scan_code  = scan_code_q;
   assign scan_valid = scan_valid_q;
   assign frame_err  = frame_err_q;

endmodule

// File: rtl/keyboard_ctl.sv
// PS/2 keyboard front end: receiver plus set-2 make/break decoder driving held-key levels.
// Define KEYBOARD_WASD_EN to also map W/A/D onto space/left/right.
module keyboard_ctl
   import keyboard_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 65_000,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       key_space,
   output logic       key_left,
   output logic       key_right,
   output logic [7:0] scan_code,
   output logic       scan_valid,
   output logic       frame_err
);

   logic [7:0] rx_code;
   logic       rx_valid;
   logic       rx_err;

   ps2_rx #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
   ) u_rx (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .scan_code  (rx_code),
      .scan_valid (rx_valid),
      .frame_err  (rx_err)
   );

   assign scan_code  = rx_code;
   assign scan_valid = rx_valid;
   assign frame_err  = rx_err;

   dec_state_t state_q, state_d;
   logic space_q, space_d;
   logic left_q, left_d;
   logic right_q, right_d;
   logic key_space_q, key_space_d;
   logic key_left_q, key_left_d;
   logic key_right_q, key_right_d;
`ifdef KEYBOARD_WASD_EN
   logic w_q, w_d;
   logic a_q, a_d;
   logic d_q, d_d;
`endif

   logic upd_c;
   logic upd_ext_c;
   logic upd_lvl_c;

   always_comb begin
      state_d   = state_q;
      space_d   = space_q;
      left_d    = left_q;
      right_d   = right_q;
      upd_c     = 1'b0;
      upd_ext_c = 1'b0;
      upd_lvl_c = 1'b0;
`ifdef KEYBOARD_WASD_EN
      w_d = w_q;
      a_d = a_q;
      d_d = d_q;
`endif

      if (rx_err) begin
         state_d = DEC_IDLE;
      end else if (rx_valid) begin
         case (state_q)
            DEC_IDLE: begin
               if (rx_code == SC_EXT) begin
                  state_d = DEC_EXT;
               end else if (rx_code == SC_BREAK) begin
                  state_d = DEC_BREAK;
               end else begin
                  upd_c     = 1'b1;
                  upd_lvl_c = 1'b1;
               end
            end
            DEC_EXT: begin
               if (rx_code == SC_BREAK) begin
                  state_d = DEC_EXT_BREAK;
               end else if (rx_code != SC_EXT) begin
                  upd_c     = 1'b1;
                  upd_ext_c = 1'b1;
                  upd_lvl_c = 1'b1;
                  state_d   = DEC_IDLE;
               end
            end
            DEC_BREAK: begin
               upd_c   = 1'b1;
               state_d = DEC_IDLE;
            end
            DEC_EXT_BREAK: begin
               upd_c     = 1'b1;
               upd_ext_c = 1'b1;
               state_d   = DEC_IDLE;
            end
            default: state_d = DEC_IDLE;
         endcase
      end

      // Keypad 6B/74 arrive without E0 and must not alias the arrow keys.
      if (upd_c) begin
         if (!upd_ext_c && rx_code == SC_SPACE) space_d = upd_lvl_c;
         if ( upd_ext_c && rx_code == SC_LEFT)  left_d  = upd_lvl_c;
         if ( upd_ext_c && rx_code == SC_RIGHT) right_d = upd_lvl_c;
`ifdef KEYBOARD_WASD_EN
         if (!upd_ext_c && rx_code == SC_W) w_d = upd_lvl_c;
         if (!upd_ext_c && rx_code == SC_A) a_d = upd_lvl_c;
         if (!upd_ext_c && rx_code == SC_D) d_d = upd_lvl_c;
`endif
      end

`ifdef KEYBOARD_WASD_EN
      key_space_d = space_d | w_d;
      key_left_d  = left_d  | a_d;
      key_right_d = right_d | d_d;
`else
      key_space_d = space_d;
      key_left_d  = left_d;
      key_right_d = right_d;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= DEC_IDLE;
         space_q     <= 1'b0;
         left_q      <= 1'b0;
         right_q     <= 1'b0;
         key_space_q <= 1'b0;
         key_left_q  <= 1'b0;
         key_right_q <= 1'b0;
`ifdef KEYBOARD_WASD_EN
         w_q         <= 1'b0;
         a_q         <= 1'b0;
         d_q         <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         space_q     <= space_d;
         left_q      <= left_d;
         right_q     <= right_d;
         key_space_q <= key_space_d;
         key_left_q  <= key_left_d;
         key_right_q <= key_right_d;
`ifdef KEYBOARD_WASD_EN
         w_q         <= w_d;
         a_q         <= a_d;
         d_q         <= d_d;
`endif
      end
   end

   assign key_space = key_space_q;
   assign key_left  = key_left_q;
   assign key_right = key_right_q;

endmodule

// File: tb/tb_keyboard_ctl.sv
// Directed bench for keyboard_ctl: table of single-frame vectors plus timeout, reset and WASD sequences.
module tb_keyboard_ctl;

   logic       clk;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_data;
   logic       key_space;
   logic       key_left;
   logic       key_right;
   logic [7:0] scan_code;
   logic       scan_valid;
   logic       frame_err;

   keyboard_ctl #(
      .TIMEOUT_CYCLES (200),
      .SYNC_STAGES    (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .key_space  (key_space),
      .key_left   (key_left),
      .key_right  (key_right),
      .scan_code  (scan_code),
      .scan_valid (scan_valid),
      .frame_err  (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;
   int sv_cnt = 0;
   int fe_cnt = 0;
   logic [7:0] last_code = 8'h00;

   always @(negedge clk) begin
      if (scan_valid) begin
         sv_cnt    = sv_cnt + 1;
         last_code = scan_code;
      end
      if (frame_err) fe_cnt = fe_cnt + 1;
   end

   typedef struct {
      logic [7:0] code;
      bit         bad_par;
      bit         stop;
      int         sv;
      int         fe;
      bit         sp;
      bit         lf;
      bit         rt;
   } vec_t;

   vec_t vecs[25];

   task automatic chk(input string name, input int act, input int exp);
      tests = tests + 1;
      if (act != exp) begin
         failed = failed + 1;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Sends the first nbits of a frame; ps2_data changes while ps2_clk is high.
   task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit stop, input int nbits);
      logic [10:0] bits;
      bits[0]   = 1'b0;
      bits[8:1] = code;
      bits[9]   = (~^code) ^ bad_par;
      bits[10]  = stop;
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         ps2_data = bits[i];
         repeat (10) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (20) @(negedge clk);
         ps2_clk = 1'b1;
         repeat (10) @(negedge clk);
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_ok(input logic [7:0] code);
      send_frame(code, 1'b0, 1'b1, 11);
      repeat (5) @(negedge clk);
   endtask

   task automatic chk_keys(input string tag, input bit sp, input bit lf, input bit rt);
      chk({tag, " key_space"}, int'(key_space), int'(sp));
      chk({tag, " key_left"},  int'(key_left),  int'(lf));
      chk({tag, " key_right"}, int'(key_right), int'(rt));
   endtask

   initial begin
      int sv0;
      int fe0;

      vecs[0]  = '{8'h29, 0, 1, 1, 0, 1, 0, 0};
      vecs[1]  = '{8'hF0, 0, 1, 1, 0, 1, 0, 0};
      vecs[2]  = '{8'h29, 0, 1, 1, 0, 0, 0, 0};
      vecs[3]  = '{8'hE0, 0, 1, 1, 0, 0, 0, 0};
      vecs[4]  = '{8'h6B, 0, 1, 1, 0, 0, 1, 0};
      vecs[5]  = '{8'hE0, 0, 1, 1, 0, 0, 1, 0};
      vecs[6]  = '{8'h74, 0, 1, 1, 0, 0, 1, 1};
      vecs[7]  = '{8'hE0, 0, 1, 1, 0, 0, 1, 1};
      vecs[8]  = '{8'hF0, 0, 1, 1, 0, 0, 1, 1};
      vecs[9]  = '{8'h6B, 0, 1, 1, 0, 0, 0, 1};
      vecs[10] = '{8'h6B, 0, 1, 1, 0, 0, 0, 1};
      vecs[11] = '{8'hE0, 0, 1, 1, 0, 0, 0, 1};
      vecs[12] = '{8'h74, 0, 1, 1, 0, 0, 0, 1};
      vecs[13] = '{8'hE0, 0, 1, 1, 0, 0, 0, 1};
      vecs[14] = '{8'hF0, 0, 1, 1, 0, 0, 0, 1};
      vecs[15] = '{8'h74, 0, 1, 1, 0, 0, 0, 0};
      vecs[16] = '{8'h29, 1, 1, 0, 1, 0, 0, 0};
      vecs[17] = '{8'h29, 0, 0, 0, 1, 0, 0, 0};
      vecs[18] = '{8'hAA, 0, 1, 1, 0, 0, 0, 0};
      vecs[19] = '{8'h29, 0, 1, 1, 0, 1, 0, 0};
      vecs[20] = '{8'h29, 0, 1, 1, 0, 1, 0, 0};
      vecs[21] = '{8'hE0, 0, 1, 1, 0, 1, 0, 0};
      vecs[22] = '{8'hF0, 1, 1, 0, 1, 1, 0, 0};
      vecs[23] = '{8'hF0, 0, 1, 1, 0, 1, 0, 0};
      vecs[24] = '{8'h29, 0, 1, 1, 0, 0, 0, 0};

      rst      = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (5) @(negedge clk);
      chk_keys("reset", 0, 0, 0);
      chk("reset scan_code", int'(scan_code), 0);
      chk("reset scan_valid", int'(scan_valid), 0);
      chk("reset frame_err", int'(frame_err), 0);
      rst = 1'b1;
      repeat (10) @(negedge clk);

      for (int i = 0; i < 25; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         sv0 = sv_cnt;
         fe0 = fe_cnt;
         send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].stop, 11);
         repeat (5) @(negedge clk);
         chk({tag, " scan_valid pulses"}, sv_cnt - sv0, vecs[i].sv);
         chk({tag, " frame_err pulses"},  fe_cnt - fe0, vecs[i].fe);
         if (vecs[i].sv == 1) chk({tag, " scan_code"}, int'(last_code), int'(vecs[i].code));
         chk_keys(tag, vecs[i].sp, vecs[i].lf, vecs[i].rt);
      end

      // Partial frame then silence: timeout must abort it and the next frame must decode.
      sv0 = sv_cnt;
      fe0 = fe_cnt;
      send_frame(8'h29, 1'b0, 1'b1, 4);
      repeat (120) @(negedge clk);
      chk("timeout early frame_err", fe_cnt - fe0, 0);
      repeat (130) @(negedge clk);
      chk("timeout frame_err", fe_cnt - fe0, 1);
      chk("timeout scan_valid", sv_cnt - sv0, 0);
      send_ok(8'h29);
      chk("post-timeout scan_valid", sv_cnt - sv0, 1);
      chk("post-timeout scan_code", int'(last_code), 32'h29);
      chk_keys("post-timeout", 1, 0, 0);

      // Reset in the middle of a frame while Space is held.
      send_frame(8'h74, 1'b0, 1'b1, 5);
      rst = 1'b0;
      #1;
      chk_keys("mid-reset", 0, 0, 0);
      chk("mid-reset scan_code", int'(scan_code), 0);
      chk("mid-reset scan_valid", int'(scan_valid), 0);
      chk("mid-reset frame_err", int'(frame_err), 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      sv0 = sv_cnt;
      fe0 = fe_cnt;
      send_ok(8'h29);
      chk("post-reset scan_valid", sv_cnt - sv0, 1);
      chk("post-reset frame_err", fe_cnt - fe0, 0);
      chk("post-reset scan_code", int'(last_code), 32'h29);
      chk_keys("post-reset", 1, 0, 0);
      send_ok(8'hF0);
      send_ok(8'h29);
      chk_keys("post-reset release", 0, 0, 0);

      // 1C alone must not reach key_left unless the WASD map is built in.
      send_ok(8'h1C);
`ifdef KEYBOARD_WASD_EN
      chk_keys("A make", 0, 1, 0);
      send_ok(8'hE0);
      send_ok(8'h6B);
      chk_keys("A+Left", 0, 1, 0);
      send_ok(8'hF0);
      send_ok(8'h1C);
      chk_keys("A released, Left held", 0, 1, 0);
      send_ok(8'hE0);
      send_ok(8'hF0);
      send_ok(8'h6B);
      chk_keys("Left released", 0, 0, 0);
`else
      chk_keys("A unmapped", 0, 0, 0);
      send_ok(8'hF0);
      send_ok(8'h1C);
      chk_keys("A break unmapped", 0, 0, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
